// File: rtl/im_port_arbiter_pkg.sv
// Shared types for the instruction-ROM port arbiter: owner/state encodings,
// the in-flight tag carried through the ROM latency, and the address check.
package im_pkg;

  typedef enum logic {OWN_FETCH = 1'b0, OWN_DBG = 1'b1} owner_e;
  typedef enum logic {FETCH_PRI = 1'b0, DBG_OWED = 1'b1} state_e;

  typedef struct packed {
    logic   vld;
    owner_e owner;
    logic   err;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

  // Byte address must be word aligned and fit inside the ROM word space.
  function automatic logic addr_err(input logic [31:0] a, input int aw);
    return (a[1:0] != 2'b00) || ((a >> (aw + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/im_port_arbiter_if.sv
// Fetch, debug and ROM-side signals of the instruction-ROM port arbiter.
interface im_port_arbiter_if #(
  parameter int AW = 10
);
  logic          f_req;
  logic [31:0]   f_addr;
  logic          f_gnt;
  logic          f_rvalid;
  logic [31:0]   f_rdata;
  logic          f_err;
  logic          f_flush;
  logic          d_req;
  logic [31:0]   d_addr;
  logic          d_gnt;
  logic          d_rvalid;
  logic [31:0]   d_rdata;
  logic          d_err;
  logic [AW-1:0] rom_addr;
  logic [31:0]   rom_q;

  modport master (
    output f_req, f_addr, f_flush, d_req, d_addr, rom_q,
    input  f_gnt, f_rvalid, f_rdata, f_err, d_gnt, d_rvalid, d_rdata, d_err, rom_addr
  );

  modport slave (
    input  f_req, f_addr, f_flush, d_req, d_addr, rom_q,
    output f_gnt, f_rvalid, f_rdata, f_err, d_gnt, d_rvalid, d_rdata, d_err, rom_addr
  );
endinterface

// File: rtl/im_port_arbiter_tag_pipe.sv
// ROM_LAT-deep tag shift register; a fetch flush kills every fetch-owned tag,
// including the one entering this cycle. The head lines up with rom_q.
module im_tag_pipe
  import im_pkg::*;
#(
  parameter int ROM_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush_fetch,
  input  tag_t tag_in,
  output tag_t head
);

  logic [ROM_LAT-1:0][TAG_W-1:0] stg;
  tag_t [ROM_LAT-1:0]            nxt;

  always_comb begin
    nxt[0] = tag_in;
    for (int i = 1; i < ROM_LAT; i++) nxt[i] = tag_t'(stg[i-1]);
    if (flush_fetch)
      for (int i = 0; i < ROM_LAT; i++)
        if (nxt[i].owner == OWN_FETCH) nxt[i].vld = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stg <= '0;
    else        stg <= nxt;
  end

  assign head = tag_t'(stg[ROM_LAT-1]);

endmodule

// File: rtl/im_port_arbiter.sv
// Two-requester arbiter for the instruction ROM read port: fetch has priority,
// a starvation counter forces a debug grant, returned words go to their owner.
module im_port_arbiter
  import im_pkg::*;
#(
  parameter int ROM_LAT    = 1,
  parameter int AW         = 10,
  parameter int STARVE_MAX = 8
) (
  input logic          clk,
  input logic          rst_n,
  im_port_arbiter_if.slave bus
);

  localparam logic [7:0] CNT_OWE = 8'(STARVE_MAX - 1);
  localparam logic [7:0] CNT_MAX = 8'(STARVE_MAX);

  state_e        state, state_nxt;
  logic [7:0]    starve_cnt;
  logic          f_gnt, d_gnt, any_gnt, d_denied;
  logic [31:0]   gnt_addr;
  logic [AW-1:0] last_addr;
  tag_t          tag_in, head;
  logic          f_hit, d_hit;
  logic [31:0]   resp_data, f_rdata_q, d_rdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= FETCH_PRI;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH_PRI: if (d_denied && starve_cnt == CNT_OWE) state_nxt = DBG_OWED;
      DBG_OWED:  if (d_gnt || !bus.d_req) state_nxt = FETCH_PRI;
      default:   state_nxt = FETCH_PRI;
    endcase
  end

  always_comb begin
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst_n) begin
      case (state)
        FETCH_PRI: begin
          f_gnt = bus.f_req;
          d_gnt = bus.d_req & ~bus.f_req;
        end
        DBG_OWED: begin
          d_gnt = bus.d_req;
          f_gnt = bus.f_req & ~bus.d_req;
        end
        default: ;
      endcase
    end
  end

  assign d_denied = bus.d_req & ~d_gnt;

  always_ff @(posedge clk) begin
    if (!rst_n || d_gnt || !bus.d_req) starve_cnt <= '0;
    else if (starve_cnt != CNT_MAX)    starve_cnt <= starve_cnt + 8'd1;
  end

  assign any_gnt  = f_gnt | d_gnt;
  assign gnt_addr = d_gnt ? bus.d_addr : bus.f_addr;

  // The ROM keeps seeing the last granted address while nobody is granted.
  always_ff @(posedge clk) begin
    if (!rst_n)       last_addr <= '0;
    else if (any_gnt) last_addr <= gnt_addr[AW+1:2];
  end

  assign bus.rom_addr = !rst_n  ? '0 :
                        any_gnt ? gnt_addr[AW+1:2] : last_addr;

  always_comb begin
    tag_in.vld   = any_gnt;
    tag_in.owner = d_gnt ? OWN_DBG : OWN_FETCH;
    tag_in.err   = addr_err(gnt_addr, AW);
  end

  im_tag_pipe #(.ROM_LAT(ROM_LAT)) u_tag_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_fetch (bus.f_flush),
    .tag_in      (tag_in),
    .head        (head)
  );

  assign f_hit     = head.vld & (head.owner == OWN_FETCH);
  assign d_hit     = head.vld & (head.owner == OWN_DBG);
  assign resp_data = head.err ? 32'd0 : bus.rom_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (f_hit) f_rdata_q <= resp_data;
      if (d_hit) d_rdata_q <= resp_data;
    end
  end

  assign bus.f_gnt    = f_gnt;
  assign bus.d_gnt    = d_gnt;
  assign bus.f_rvalid = f_hit;
  assign bus.d_rvalid = d_hit;
  assign bus.f_err    = f_hit & head.err;
  assign bus.d_err    = d_hit & head.err;
  assign bus.f_rdata  = f_hit ? resp_data : f_rdata_q;
  assign bus.d_rdata  = d_hit ? resp_data : d_rdata_q;

endmodule

// File: tb/tb_im_port_arbiter.sv
// Scenario bench for im_port_arbiter: grants checked inline per task, responses
// checked by a negedge monitor against a queue of expected returns.
module tb_im_port_arbiter;

  localparam int LAT = 3;
  localparam int AW  = 10;
  localparam int SM  = 8;

  typedef struct {
    int          due;
    logic        own;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  logic [31:0] last_f = '0;
  logic [31:0] last_d = '0;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [AW-1:0] rom_pipe [LAT];

  im_port_arbiter_if #(.AW(AW)) bus ();

  im_port_arbiter #(.ROM_LAT(LAT), .AW(AW), .STARVE_MAX(SM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rom_val(input logic [AW-1:0] w);
    return 32'hC0DE_0000 ^ (32'(w) * 32'h0001_0003);
  endfunction

  // ROM model: data for an address appears LAT cycles after it is presented.
  always @(posedge clk) begin
    rom_pipe[0] <= bus.rom_addr;
    for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign bus.rom_q = rom_val(rom_pipe[LAT-1]);

  always @(negedge clk) begin
    if (mon_en) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        n_chk++; n_fail++;
        $display("FAIL sb_missed: response due cycle %0d not seen, now %0d", sb[0].due, cyc);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        n_chk++;
        if (mon_e.own == 1'b0) begin
          if ({bus.f_rvalid, bus.f_err, bus.f_rdata, bus.d_rvalid, bus.d_rdata} !==
              {1'b1, mon_e.err, mon_e.data, 1'b0, last_d}) begin
            n_fail++;
            $display("FAIL f_resp cyc %0d: got v=%b e=%b d=%h dv=%b dd=%h, exp v=1 e=%b d=%h dv=0 dd=%h",
                     cyc, bus.f_rvalid, bus.f_err, bus.f_rdata, bus.d_rvalid, bus.d_rdata,
                     mon_e.err, mon_e.data, last_d);
          end
          last_f = mon_e.data;
        end else begin
          if ({bus.d_rvalid, bus.d_err, bus.d_rdata, bus.f_rvalid, bus.f_rdata} !==
              {1'b1, mon_e.err, mon_e.data, 1'b0, last_f}) begin
            n_fail++;
            $display("FAIL d_resp cyc %0d: got v=%b e=%b d=%h fv=%b fd=%h, exp v=1 e=%b d=%h fv=0 fd=%h",
                     cyc, bus.d_rvalid, bus.d_err, bus.d_rdata, bus.f_rvalid, bus.f_rdata,
                     mon_e.err, mon_e.data, last_f);
          end
          last_d = mon_e.data;
        end
      end else begin
        n_chk++;
        if ({bus.f_rvalid, bus.d_rvalid, bus.f_err, bus.d_err, bus.f_rdata, bus.d_rdata} !==
            {4'b0000, last_f, last_d}) begin
          n_fail++;
          $display("FAIL idle_resp cyc %0d: got fv=%b dv=%b fe=%b de=%b fd=%h dd=%h, exp 0 0 0 0 %h %h",
                   cyc, bus.f_rvalid, bus.d_rvalid, bus.f_err, bus.d_err, bus.f_rdata, bus.d_rdata,
                   last_f, last_d);
        end
      end
    end
  end

  task automatic drive(input logic fr, input logic [31:0] fa, input logic dr,
                       input logic [31:0] da, input logic fl);
    @(posedge clk); #1;
    bus.f_req = fr; bus.f_addr = fa; bus.d_req = dr; bus.d_addr = da; bus.f_flush = fl;
  endtask

  task automatic push(input logic own, input logic [31:0] a);
    exp_t e;
    e.due  = cyc + LAT;
    e.own  = own;
    e.err  = (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
    e.data = e.err ? 32'd0 : rom_val(a[AW+1:2]);
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      n_chk++;
      if ({bus.f_gnt, bus.d_gnt} !== 2'b00) begin
        n_fail++;
        $display("FAIL idle_gnt cyc %0d: got %b exp 00", cyc, {bus.f_gnt, bus.d_gnt});
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.f_req = 1'b1; bus.f_addr = 32'h10; bus.d_req = 1'b1; bus.d_addr = 32'h20; bus.f_flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({bus.f_gnt, bus.d_gnt, bus.rom_addr} !== {2'b00, {AW{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_gnt: got gnt=%b rom_addr=%h exp 00 / 0", {bus.f_gnt, bus.d_gnt}, bus.rom_addr);
    end
    n_chk++;
    if ({bus.f_rvalid, bus.d_rvalid, bus.f_err, bus.d_err, bus.f_rdata, bus.d_rdata} !== 68'd0) begin
      n_fail++;
      $display("FAIL reset_out: got fv=%b dv=%b fd=%h dd=%h exp all 0",
               bus.f_rvalid, bus.d_rvalid, bus.f_rdata, bus.d_rdata);
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b1; mon_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_fetch;
    drive(1'b1, 32'h0000_0010, 1'b0, 32'h0, 1'b0);
    push(1'b0, 32'h0000_0010);
    @(negedge clk);
    n_chk++;
    if ({bus.f_gnt, bus.d_gnt, bus.rom_addr} !== {2'b10, 10'd4}) begin
      n_fail++;
      $display("FAIL single_gnt: got gnt=%b rom_addr=%h exp 10 / 004", {bus.f_gnt, bus.d_gnt}, bus.rom_addr);
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    n_chk++;
    if (bus.rom_addr !== 10'd4) begin
      n_fail++;
      $display("FAIL rom_addr_hold: got %h exp 004", bus.rom_addr);
    end
    idle(LAT);
  endtask

  task automatic test_addr_err;
    logic [31:0] addrs [5];
    logic        owns  [5];
    addrs = '{32'h0000_1002, 32'h0000_0FFC, 32'h0000_1000, 32'h0000_0006, 32'h8000_0000};
    owns  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      logic [31:0] a;
      a = addrs[i];
      drive(!owns[i], a, owns[i], a, 1'b0);
      push(owns[i], a);
      @(negedge clk);
      n_chk++;
      if ({bus.f_gnt, bus.d_gnt, bus.rom_addr} !== {!owns[i], owns[i], a[AW+1:2]}) begin
        n_fail++;
        $display("FAIL err_gnt[%0d]: got gnt=%b rom_addr=%h exp %b%b / %h", i,
                 {bus.f_gnt, bus.d_gnt}, bus.rom_addr, !owns[i], owns[i], a[AW+1:2]);
      end
    end
    idle(LAT + 1);
  endtask

  task automatic test_starve;
    for (int i = 0; i < 27; i++) begin
      logic        ed;
      logic [31:0] fa;
      ed = (i % 9 == 8);
      fa = 32'h100 + 32'(4 * i);
      drive(1'b1, fa, 1'b1, 32'h44, 1'b0);
      if (ed) push(1'b1, 32'h44);
      else    push(1'b0, fa);
      @(negedge clk);
      n_chk++;
      if ({bus.f_gnt, bus.d_gnt} !== {!ed, ed}) begin
        n_fail++;
        $display("FAIL starve_gnt[%0d]: got %b exp %b%b", i, {bus.f_gnt, bus.d_gnt}, !ed, ed);
      end
      n_chk++;
      if (bus.rom_addr !== (ed ? 10'h011 : fa[AW+1:2])) begin
        n_fail++;
        $display("FAIL starve_addr[%0d]: got %h exp %h", i, bus.rom_addr, ed ? 10'h011 : fa[AW+1:2]);
      end
    end
    idle(LAT + 1);
  endtask

  task automatic test_flush;
    drive(1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    push(1'b0, 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 32'h20, 1'b0);
    push(1'b1, 32'h20);
    @(negedge clk);
    n_chk++;
    if ({bus.f_gnt, bus.d_gnt} !== 2'b01) begin
      n_fail++;
      $display("FAIL flush_dgnt: got %b exp 01", {bus.f_gnt, bus.d_gnt});
    end
    drive(1'b1, 32'h8, 1'b0, 32'h0, 1'b1);
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].own == 1'b0 && sb[i].due > cyc) sb.delete(i);
    @(negedge clk);
    n_chk++;
    if ({bus.f_gnt, bus.d_gnt} !== 2'b10) begin
      n_fail++;
      $display("FAIL flush_fgnt: got %b exp 10", {bus.f_gnt, bus.d_gnt});
    end
    drive(1'b1, 32'h8, 1'b0, 32'h0, 1'b0);
    push(1'b0, 32'h8);
    @(negedge clk);
    idle(LAT + 1);
  endtask

  task automatic test_interleave;
    for (int i = 0; i < 4; i++) begin
      logic        own;
      logic [31:0] a;
      own = i[0];
      a   = 32'h240 + 32'(8 * i);
      drive(!own, a, own, a, 1'b0);
      push(own, a);
      @(negedge clk);
      n_chk++;
      if ({bus.f_gnt, bus.d_gnt} !== {!own, own}) begin
        n_fail++;
        $display("FAIL inter_gnt[%0d]: got %b exp %b%b", i, {bus.f_gnt, bus.d_gnt}, !own, own);
      end
    end
    idle(LAT + 1);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a;
      a = 32'hFE8 + 32'(4 * i);
      drive(1'b1, a, 1'b0, 32'h0, 1'b0);
      push(1'b0, a);
      @(negedge clk);
      n_chk++;
      if ({bus.f_gnt, bus.rom_addr} !== {1'b1, a[AW+1:2]}) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got gnt=%b rom_addr=%h exp 1 / %h", i, bus.f_gnt, bus.rom_addr, a[AW+1:2]);
      end
    end
    idle(LAT + 1);
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i), 1'b1, 32'h60, 1'b0);
      push(1'b0, 32'h200 + 32'(4 * i));
      @(negedge clk);
    end
    drive(1'b1, 32'h300, 1'b1, 32'h60, 1'b0);
    rst_n = 1'b0;
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].due > cyc) sb.delete(i);
    @(negedge clk);
    n_chk++;
    if ({bus.f_gnt, bus.d_gnt, bus.rom_addr} !== {2'b00, {AW{1'b0}}}) begin
      n_fail++;
      $display("FAIL mid_reset_gnt: got gnt=%b rom_addr=%h exp 00 / 0", {bus.f_gnt, bus.d_gnt}, bus.rom_addr);
    end
    // Post-reset both request: fetch must win for 8 cycles, debug on the 9th.
    for (int i = 0; i < 9; i++) begin
      logic        ed;
      logic [31:0] fa;
      ed = (i == 8);
      fa = 32'h380 + 32'(4 * i);
      drive(1'b1, fa, 1'b1, 32'h60, 1'b0);
      if (i == 0) begin
        rst_n = 1'b1; last_f = '0; last_d = '0;
      end
      if (ed) push(1'b1, 32'h60);
      else    push(1'b0, fa);
      @(negedge clk);
      if (i == 0) begin
        n_chk++;
        if ({bus.f_rdata, bus.d_rdata, bus.f_err, bus.d_err} !== 66'd0) begin
          n_fail++;
          $display("FAIL mid_reset_out: got fd=%h dd=%h fe=%b de=%b exp 0", bus.f_rdata, bus.d_rdata,
                   bus.f_err, bus.d_err);
        end
      end
      n_chk++;
      if ({bus.f_gnt, bus.d_gnt} !== {!ed, ed}) begin
        n_fail++;
        $display("FAIL mid_reset_starve[%0d]: got %b exp %b%b", i, {bus.f_gnt, bus.d_gnt}, !ed, ed);
      end
    end
    idle(LAT + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_addr_err();
    test_starve();
    test_flush();
    test_interleave();
    test_back_to_back();
    test_reset_mid();
    n_chk++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending responses exp 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
